pwm_peripheral: RTL and testbench

Consumes the enable and duty-cycle registers written by the SPI register-file stage and drives 16 output pins. Each pin is forced low, held static high, or driven by one shared PWM waveform. A prescaler and an 8-bit period counter generate that waveform. The block sits directly between the SPI register outputs and the top-level output pins.

---
 rtl/pwm_peripheral_if.sv | 21 ++
 rtl/pwm_peripheral.sv | 103 ++++++++++
 tb/tb_pwm_peripheral.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_peripheral_if.sv
// Register-side and pin-side signals of the PWM peripheral.
// The register file drives through the master modport; pwm_peripheral uses the slave modport.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is off, static high or driven by one shared PWM waveform.
// Define PWM_DUTY_SHADOW_EN to latch the duty value only at the period wrap.
module pwm_peripheral #(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam int unsigned     PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [7:0]       pwm_cnt;
  logic             wrap;
  logic [7:0]       duty_active;
  logic             pwm_level;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_next;
  logic [15:0]      out_q;
  logic             period_start_q;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Period counter wraps naturally modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= wrap;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow;

  // Loaded on the same wrap that raises period_start, so each period is whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= 8'h00;
    end else if (wrap) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  assign duty_active = duty_shadow;
`else
  assign duty_active = bus.pwm_duty_cycle;
`endif

  // NOTE: every always_comb output gets a value on every path (here a default
  // first), otherwise synthesis infers a latch.
  always_comb begin
    pwm_level = 1'b0;
    out_next  = 16'h0000;
    if (duty_active == 8'hFF) begin
      pwm_level = 1'b1;
    end else begin
      pwm_level = (pwm_cnt < duty_active);
    end
    out_next = en_out & (~en_pwm | {16{pwm_level}});
  end

  // Registering the pin drive keeps the outputs glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_next;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: directed scenarios plus random register
// traffic, compared every cycle against a time-based arithmetic model.
module tb_pwm_peripheral;

  localparam int P      = 3;
  localparam int PERIOD = 256 * P;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  // Model state: edges since reset release, and the duty latched at the last wrap.
  int         n = 0;
  logic [7:0] model_shadow = 8'h00;

  pwm_peripheral_if bus ();

  pwm_peripheral #(.PRESCALE_DIV(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // One clock: predict from the time since release, apply the edge, compare at negedge.
  task automatic step();
    int         cnt;
    logic [7:0] d;
    logic       lvl;
    logic [15:0] eo, ep, exp_out;
    cnt = (n / P) % 256;
`ifdef PWM_DUTY_SHADOW_EN
    d = model_shadow;
`else
    d = bus.pwm_duty_cycle;
`endif
    lvl = (d == 8'hFF) ? 1'b1 : (cnt < int'(d));
    eo  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    ep  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    exp_out = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (eo[i]) exp_out[i] = ep[i] ? lvl : 1'b1;
    end
    @(posedge clk);
    n++;
    if (n % PERIOD == 0) model_shadow = bus.pwm_duty_cycle;
    @(negedge clk);
    check("out", {16'h0, bus.out}, {16'h0, exp_out});
    check("period_start", {31'h0, bus.period_start}, {31'h0, (n % PERIOD == 0)});
  endtask

  task automatic run_to_boundary();
    for (int k = 0; k < PERIOD; k++) begin
      step();
      if (n % PERIOD == 0) break;
    end
  endtask

  // High cycles of one pin over one full period starting from the current position.
  task automatic measure_high(input int pin, output int hi);
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step();
      hi += int'(bus.out[pin]);
    end
  endtask

  int hi;
  int m;
  logic [7:0] duty_list [4] = '{8'h80, 8'h00, 8'hFF, 8'h01};

  initial begin
    // Reset with everything enabled.
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    bus.pwm_duty_cycle = 8'h80;
    repeat (3) @(negedge clk);
    check("reset_out", {16'h0, bus.out}, 32'h0);
    check("reset_period_start", {31'h0, bus.period_start}, 32'h0);
    rst_n = 1'b1;
    n = 0;
    model_shadow = 8'h00;

    // First period_start arrives 256*P clocks after release.
    m = 0;
    do begin
      step();
      m++;
    end while (bus.period_start !== 1'b1 && m < PERIOD + 4);
    check("first_period_start", m, PERIOD);

    // Gating: en_out off overrides PWM select.
    set_en(16'h0000, 16'hFFFF);
    for (int k = 0; k < 2 * PERIOD; k++) step();

    // Static high pattern, one clock after the write.
    set_en(16'hA5A5, 16'h0000);
    step();
    check("static_first", {16'h0, bus.out}, 32'hA5A5);
    for (int k = 0; k < 2 * PERIOD; k++) step();

    // Duty sweep over whole periods aligned to the wrap.
    set_en(16'hFFFF, 16'hFFFF);
    foreach (duty_list[j]) begin
      bus.pwm_duty_cycle = duty_list[j];
      run_to_boundary();
      measure_high(0, hi);
      check($sformatf("duty_%02h_pin0", duty_list[j]), hi,
            (duty_list[j] == 8'hFF) ? PERIOD : int'(duty_list[j]) * P);
      measure_high(15, hi);
      check($sformatf("duty_%02h_pin15", duty_list[j]), hi,
            (duty_list[j] == 8'hFF) ? PERIOD : int'(duty_list[j]) * P);
    end

    // Mixed: PWM on 3..0, static on 7..4, off on 15..8.
    set_en(16'h00FF, 16'h000F);
    bus.pwm_duty_cycle = 8'h40;
    run_to_boundary();
    measure_high(2, hi);
    check("mixed_pwm_pin", hi, 64 * P);
    measure_high(5, hi);
    check("mixed_static_pin", hi, PERIOD);
    measure_high(12, hi);
    check("mixed_off_pin", hi, 0);

    // Mid-period duty write at pwm_cnt = 0x20.
    set_en(16'hFFFF, 16'hFFFF);
    bus.pwm_duty_cycle = 8'h40;
    run_to_boundary();
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == 32 * P) bus.pwm_duty_cycle = 8'hC0;
      step();
      hi += int'(bus.out[0]);
    end
`ifdef PWM_DUTY_SHADOW_EN
    check("midwrite_period", hi, 64 * P);
`else
    check("midwrite_period", hi, 192 * P);
`endif
    measure_high(0, hi);
    check("after_midwrite_period", hi, 192 * P);

    // Random register traffic, including the duty corner values.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0)
        set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 5))
          0:       bus.pwm_duty_cycle = 8'h00;
          1:       bus.pwm_duty_cycle = 8'h01;
          2:       bus.pwm_duty_cycle = 8'hFE;
          3:       bus.pwm_duty_cycle = 8'hFF;
          default: bus.pwm_duty_cycle = 8'($urandom);
        endcase
      end
      step();
    end

    // Asynchronous reset mid-period drops the pins immediately.
    set_en(16'hFFFF, 16'h0000);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {16'h0, bus.out}, 32'h0);
    check("async_reset_period_start", {31'h0, bus.period_start}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    model_shadow = 8'h00;
    set_en(16'hFFFF, 16'hFFFF);
    bus.pwm_duty_cycle = 8'h80;
    m = 0;
    do begin
      step();
      m++;
    end while (bus.period_start !== 1'b1 && m < PERIOD + 4);
    check("restart_period_start", m, PERIOD);
    measure_high(7, hi);
    check("restart_duty_80", hi, 128 * P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
